// File: rtl/laser_score_pkg.sv
// Shared constants and state encoding for the laser scoring block.
package laser_score_pkg;
  // Points per frame.
  localparam int NPTS    = 40;
  // Squared circle radius.
  localparam int R2      = 16;
  // Coordinate width.
  localparam int DATA_W  = 4;
  // Score width (0..40).
  localparam int SCORE_W = 6;
  // Squared-distance width: 15*15 + 15*15 = 450 fits in 9 bits.
  localparam int D2_W    = 9;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    WAIT = 2'd1,
    EVAL = 2'd2,
    OUT  = 2'd3
  } state_t;
endpackage

// File: rtl/laser_in_circle.sv
// Combinational point-in-circle test: squared distance against R2.
module laser_in_circle
  import laser_score_pkg::*;
(
  input  logic [DATA_W-1:0] px,
  input  logic [DATA_W-1:0] py,
  input  logic [DATA_W-1:0] cx,
  input  logic [DATA_W-1:0] cy,
  output logic              in
);

  // Absolute coordinate difference via a signed subtraction one bit wider.
  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[DATA_W] ? DATA_W'(-d) : DATA_W'(d);
  endfunction

  logic [D2_W-1:0] dx;
  logic [D2_W-1:0] dy;
  logic [D2_W-1:0] d2;

  // Squared distance in 9 bits, boundary (exactly R2) counts as inside.
  always_comb begin
    dx = D2_W'(abs_diff(px, cx));
    dy = D2_W'(abs_diff(py, cy));
    d2 = dx * dx + dy * dy;
    in = (d2 <= D2_W'(R2));
  end

endmodule

// File: rtl/laser_score.sv
// Frame buffer, two-circle coverage scorer and best-result tracker.
module laser_score
  import laser_score_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               PT_VALID,
  input  logic [DATA_W-1:0]  X,
  input  logic [DATA_W-1:0]  Y,
  input  logic               RES_VALID,
  input  logic [DATA_W-1:0]  C1X,
  input  logic [DATA_W-1:0]  C1Y,
  input  logic [DATA_W-1:0]  C2X,
  input  logic [DATA_W-1:0]  C2Y,
  output logic [SCORE_W-1:0] SCORE,
  output logic               SCORE_VALID,
  output logic [SCORE_W-1:0] BEST_SCORE,
  output logic [DATA_W-1:0]  BEST_C1X,
  output logic [DATA_W-1:0]  BEST_C1Y,
  output logic [DATA_W-1:0]  BEST_C2X,
  output logic [DATA_W-1:0]  BEST_C2Y,
  output logic               ERR
);

  state_t state;
  state_t state_nxt;

  logic [SCORE_W-1:0] cnt;
  logic [SCORE_W-1:0] idx;
  logic [SCORE_W-1:0] acc;

  logic [DATA_W-1:0] buf_x [NPTS];
  logic [DATA_W-1:0] buf_y [NPTS];
  logic [DATA_W-1:0] c1x, c1y, c2x, c2y;

  logic               last_wr;
  logic               cap;
  logic               eval_last;
  logic               in1, in2, hit;
  logic [SCORE_W-1:0] final_cnt;

  assign last_wr   = (state == LOAD) && PT_VALID && (cnt == SCORE_W'(NPTS - 1));
  assign cap       = (last_wr && RES_VALID) || ((state == WAIT) && RES_VALID);
  assign eval_last = (state == EVAL) && (idx == SCORE_W'(NPTS - 1));
  assign hit       = in1 | in2;
  assign final_cnt = acc + SCORE_W'(hit);

  laser_in_circle u_circ1 (
    .px (buf_x[idx]),
    .py (buf_y[idx]),
    .cx (c1x),
    .cy (c1y),
    .in (in1)
  );

  laser_in_circle u_circ2 (
    .px (buf_x[idx]),
    .py (buf_y[idx]),
    .cx (c2x),
    .cy (c2y),
    .in (in2)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state: a RES_VALID coinciding with the 40th write skips WAIT.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD: if (last_wr) state_nxt = RES_VALID ? EVAL : WAIT;
      WAIT: if (RES_VALID) state_nxt = EVAL;
      EVAL: if (eval_last) state_nxt = OUT;
      OUT:  state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Point buffer and captured centres; data only, never reset.
  always_ff @(posedge CLK) begin
    if ((state == LOAD) && PT_VALID) begin
      buf_x[cnt] <= X;
      buf_y[cnt] <= Y;
    end
    if (cap) begin
      c1x <= C1X;
      c1y <= C1Y;
      c2x <= C2X;
      c2y <= C2Y;
    end
  end

  // Load counter, evaluation index/accumulator and sticky error.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      idx <= '0;
      acc <= '0;
      ERR <= 1'b0;
    end else begin
      if ((state == LOAD) && PT_VALID)
        cnt <= last_wr ? '0 : cnt + 1'b1;
      if ((state == LOAD) && RES_VALID && !last_wr)
        ERR <= 1'b1;
      if (cap) begin
        idx <= '0;
        acc <= '0;
      end else if ((state == EVAL) && !eval_last) begin
        idx <= idx + 1'b1;
        acc <= final_cnt;
      end
    end
  end

  // Result and best-so-far registers, loaded on the final evaluation edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SCORE       <= '0;
      SCORE_VALID <= 1'b0;
      BEST_SCORE  <= '0;
      BEST_C1X    <= '0;
      BEST_C1Y    <= '0;
      BEST_C2X    <= '0;
      BEST_C2Y    <= '0;
    end else begin
      SCORE_VALID <= eval_last;
      if (eval_last) begin
        SCORE <= final_cnt;
        if (final_cnt > BEST_SCORE) begin
          BEST_SCORE <= final_cnt;
          BEST_C1X   <= c1x;
          BEST_C1Y   <= c1y;
          BEST_C2X   <= c2x;
          BEST_C2Y   <= c2y;
        end
      end
    end
  end

endmodule

// File: tb/tb_laser_score.sv
// Self-checking bench for laser_score: directed frames plus random frames
// scored against a plain-arithmetic coverage model.
module tb_laser_score;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PT_VALID = 1'b0;
  logic [3:0] X = '0, Y = '0;
  logic       RES_VALID = 1'b0;
  logic [3:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
  logic [5:0] SCORE;
  logic       SCORE_VALID;
  logic [5:0] BEST_SCORE;
  logic [3:0] BEST_C1X, BEST_C1Y, BEST_C2X, BEST_C2Y;
  logic       ERR;

  laser_score dut (
    .CLK         (CLK),
    .RST         (RST),
    .PT_VALID    (PT_VALID),
    .X           (X),
    .Y           (Y),
    .RES_VALID   (RES_VALID),
    .C1X         (C1X),
    .C1Y         (C1Y),
    .C2X         (C2X),
    .C2Y         (C2Y),
    .SCORE       (SCORE),
    .SCORE_VALID (SCORE_VALID),
    .BEST_SCORE  (BEST_SCORE),
    .BEST_C1X    (BEST_C1X),
    .BEST_C1Y    (BEST_C1Y),
    .BEST_C2X    (BEST_C2X),
    .BEST_C2Y    (BEST_C2Y),
    .ERR         (ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int ref_x [40];
  int ref_y [40];
  int m_best, m_b1x, m_b1y, m_b2x, m_b2y;
  int m_err;
  int m_score;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Points covered by either circle, each point counted once.
  function automatic int model_score(input int ax, input int ay, input int bx, input int by);
    int s;
    s = 0;
    for (int i = 0; i < 40; i++) begin
      if ((ref_x[i] - ax) ** 2 + (ref_y[i] - ay) ** 2 <= 16 ||
          (ref_x[i] - bx) ** 2 + (ref_y[i] - by) ** 2 <= 16)
        s++;
    end
    return s;
  endfunction

  task automatic model_reset();
    m_best = 0; m_b1x = 0; m_b1y = 0; m_b2x = 0; m_b2y = 0;
    m_err = 0; m_score = 0;
  endtask

  task automatic drive_centres(input int ax, input int ay, input int bx, input int by);
    C1X = 4'(ax); C1Y = 4'(ay); C2X = 4'(bx); C2Y = 4'(by);
  endtask

  // Stream points lo..hi; optionally raise RES_VALID on the 40th point.
  task automatic load_range(input int lo, input int hi, input bit res_last,
                            input int ax, input int ay, input int bx, input int by);
    for (int i = lo; i <= hi; i++) begin
      PT_VALID = 1'b1;
      X = 4'(ref_x[i]);
      Y = 4'(ref_y[i]);
      if (res_last && i == 39) begin
        RES_VALID = 1'b1;
        drive_centres(ax, ay, bx, by);
      end
      tick();
      PT_VALID  = 1'b0;
      RES_VALID = 1'b0;
    end
  endtask

  task automatic expect_frame(input int ax, input int ay, input int bx, input int by);
    m_score = model_score(ax, ay, bx, by);
    if (m_score > m_best) begin
      m_best = m_score; m_b1x = ax; m_b1y = ay; m_b2x = bx; m_b2y = by;
    end
  endtask

  // Capture centres (unless already captured with the 40th point), then
  // count cycles to SCORE_VALID and check every output.
  task automatic score_frame(input string tag, input bit captured, input bit noise,
                             input int ax, input int ay, input int bx, input int by);
    int  lat;
    bit  seen;
    expect_frame(ax, ay, bx, by);
    if (!captured) begin
      repeat ($urandom_range(0, 3)) tick();
      RES_VALID = 1'b1;
      drive_centres(ax, ay, bx, by);
      tick();
      RES_VALID = 1'b0;
    end
    lat = 0;
    seen = 0;
    while (!seen && lat < 60) begin
      if (noise && lat >= 3 && lat < 8) begin
        RES_VALID = 1'b1;
        PT_VALID  = 1'b1;
        X = 4'($urandom); Y = 4'($urandom);
        drive_centres($urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 15));
      end else begin
        RES_VALID = 1'b0;
        PT_VALID  = 1'b0;
      end
      tick();
      lat++;
      if (SCORE_VALID === 1'b1) seen = 1;
    end
    RES_VALID = 1'b0;
    PT_VALID  = 1'b0;
    check({tag, "_latency"}, seen ? lat : -1, 40);
    check({tag, "_score"}, SCORE, m_score);
    check({tag, "_best"}, BEST_SCORE, m_best);
    check({tag, "_best_c1x"}, BEST_C1X, m_b1x);
    check({tag, "_best_c1y"}, BEST_C1Y, m_b1y);
    check({tag, "_best_c2x"}, BEST_C2X, m_b2x);
    check({tag, "_best_c2y"}, BEST_C2Y, m_b2y);
    check({tag, "_err"}, ERR, m_err);
    tick();
    check({tag, "_valid_fall"}, SCORE_VALID, 0);
    check({tag, "_score_hold"}, SCORE, m_score);
  endtask

  initial begin
    int ax, ay, bx, by;
    bit on_last;
    model_reset();

    // Reset state.
    repeat (2) tick();
    RST = 1'b0;
    check("rst_score", SCORE, 0);
    check("rst_valid", SCORE_VALID, 0);
    check("rst_best", BEST_SCORE, 0);
    check("rst_err", ERR, 0);
    tick();

    // Radius boundary: d2=16 inside, d2=18 outside.
    for (int i = 0; i < 40; i++) begin ref_x[i] = 12; ref_y[i] = 12; end
    ref_x[0] = 4; ref_y[0] = 0;
    ref_x[1] = 3; ref_y[1] = 3;
    load_range(0, 39, 0, 0, 0, 0, 0);
    score_frame("radius", 0, 0, 0, 0, 0, 0);
    check("radius_is_one", SCORE, 1);

    // Random frames: points clustered near random centres.
    for (int f = 0; f < 5; f++) begin
      ax = $urandom_range(0, 15); ay = $urandom_range(0, 15);
      bx = $urandom_range(0, 15); by = $urandom_range(0, 15);
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          ref_x[i] = $urandom_range(0, 15); ref_y[i] = $urandom_range(0, 15);
        end else begin
          ref_x[i] = (ax + $urandom_range(0, 6) - 3) & 15;
          ref_y[i] = (ay + $urandom_range(0, 6) - 3) & 15;
        end
      end
      on_last = 1'($urandom_range(0, 1));
      load_range(0, 39, on_last, ax, ay, bx, by);
      score_frame("random", on_last, 1'($urandom_range(0, 1)), ax, ay, bx, by);
    end

    // Overlapping circles count a point once; then disjoint circles.
    for (int i = 0; i < 40; i++) begin
      ref_x[i] = (i < 20) ? 0 : 15;
      ref_y[i] = ref_x[i];
    end
    load_range(0, 39, 0, 0, 0, 0, 0);
    score_frame("same_ctr", 0, 0, 0, 0, 0, 0);
    check("same_ctr_twenty", SCORE, 20);
    load_range(0, 39, 0, 0, 0, 0, 0);
    score_frame("two_ctr", 0, 0, 0, 0, 15, 15);
    check("two_ctr_best_c2x", BEST_C2X, 15);

    // Premature RES_VALID: error, centres discarded, frame continues.
    for (int i = 0; i < 40; i++) begin ref_x[i] = $urandom_range(0, 15); ref_y[i] = $urandom_range(0, 15); end
    load_range(0, 9, 0, 0, 0, 0, 0);
    RES_VALID = 1'b1;
    drive_centres(15, 0, 0, 15);
    tick();
    RES_VALID = 1'b0;
    m_err = 1;
    check("early_err", ERR, 1);
    check("early_no_valid", SCORE_VALID, 0);
    load_range(10, 39, 0, 0, 0, 0, 0);
    tick();
    check("early_no_valid_wait", SCORE_VALID, 0);
    score_frame("early", 0, 0, 7, 7, 3, 12);

    // RES_VALID with the 40th point, with stray RES/PT during evaluation.
    for (int i = 0; i < 40; i++) begin ref_x[i] = $urandom_range(2, 10); ref_y[i] = $urandom_range(2, 10); end
    load_range(0, 39, 1, 5, 5, 9, 9);
    score_frame("same_edge", 1, 1, 5, 5, 9, 9);

    // All points at (8,8): full score, tie keeps the earlier best.
    for (int i = 0; i < 40; i++) begin ref_x[i] = 8; ref_y[i] = 8; end
    load_range(0, 39, 0, 0, 0, 0, 0);
    score_frame("full", 0, 0, 8, 8, 0, 0);
    check("full_forty", SCORE, 40);

    // Reset in the middle of evaluation.
    load_range(0, 39, 0, 0, 0, 0, 0);
    RES_VALID = 1'b1;
    drive_centres(8, 8, 0, 0);
    tick();
    RES_VALID = 1'b0;
    repeat (20) tick();
    RST = 1'b1;
    #2;
    check("midrst_score", SCORE, 0);
    check("midrst_valid", SCORE_VALID, 0);
    check("midrst_best", BEST_SCORE, 0);
    check("midrst_bc1x", BEST_C1X, 0);
    check("midrst_bc2y", BEST_C2Y, 0);
    check("midrst_err", ERR, 0);
    tick();
    RST = 1'b0;
    model_reset();
    tick();
    for (int i = 0; i < 40; i++) begin ref_x[i] = $urandom_range(0, 15); ref_y[i] = $urandom_range(0, 15); end
    load_range(0, 39, 0, 0, 0, 0, 0);
    score_frame("post_rst", 0, 0, 4, 11, 11, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
